// File: rtl/byte_mem_pkg.sv
// Shared constants, phase encoding and sizing helpers for the byte-masked memory responder.
// Latency: none; definitions only.
// Backpressure: none; definitions only.
package byte_mem_pkg;

   // Width of the wait-state counter; it bounds the number of hold cycles to 15
   localparam int CNT_W    = 4;
   localparam int MAX_WAIT = 15;

   // Phase of the current request, decoded each cycle from enable and the wait counter
   typedef enum logic [1:0] {
      PH_IDLE,
      PH_WAIT,
      PH_ACCEPT
   } phase_t;

   // Number of byte-offset address bits below the word index
   function automatic int lowBit(input int dataByte);
      return $clog2(dataByte);
   endfunction

   // Number of word-index address bits
   function automatic int idxBits(input int depth);
      return $clog2(depth);
   endfunction

   // True when v is a positive power of two
   function automatic bit isPow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/byte_mem_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
// Latency: read data registered one cycle after readEn; a write is visible to the next cycle's read.
// Backpressure: none; one read or write per cycle whenever enabled.
module byte_mem_array
   import byte_mem_pkg::*;
#(
   parameter int DATA_BYTE = 8,
   parameter int DEPTH     = 1024
) (
   input  logic                     clk_i,
   input  logic                     writeEn,
   input  logic                     readEn,
   input  logic [DATA_BYTE-1:0]     byteMask,
   input  logic [idxBits(DEPTH)-1:0] wordIdx,
   input  logic [DATA_BYTE*8-1:0]   writeData,
   output logic [DATA_BYTE*8-1:0]   readData
);

   // Contents are deliberately left without reset so the array can map onto block RAM
   logic [DATA_BYTE*8-1:0] mem [DEPTH];

   // Byte-masked write and registered read of the addressed word
   always_ff @(posedge clk_i) begin
      if (writeEn) begin
         for (int b = 0; b < DATA_BYTE; b++) begin
            if (byteMask[b]) begin
               mem[wordIdx][b*8 +: 8] <= writeData[b*8 +: 8];
            end
         end
      end
      if (readEn) begin
         readData <= mem[wordIdx];
      end
   end

endmodule

// File: rtl/byte_mem_responder.sv
// Memory-side responder: byte-masked scratch RAM that inserts WAIT_CYCLES hold cycles per access.
// Latency: request accepted after WAIT_CYCLES hold cycles; read data valid the cycle after acceptance.
// Backpressure: hold_o stalls the initiator combinationally while the wait counter runs.
module byte_mem_responder
   import byte_mem_pkg::*;
#(
   parameter int DATA_BYTE   = 8,
   parameter int ADDR_SIZE   = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic                   isWrite_i,
   input  logic [DATA_BYTE-1:0]   writeMask_i,
   input  logic [ADDR_SIZE-1:0]   addr_i,
   input  logic [DATA_BYTE*8-1:0] writeData_i,
   output logic [DATA_BYTE*8-1:0] readData_o,
   output logic                   hold_o
);

   localparam int               LOW_B    = lowBit(DATA_BYTE);
   localparam int               IDX_W    = idxBits(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cntNext;
   phase_t                 phase;
   logic                   accept;
   logic [ADDR_SIZE-1:0]   wordAddr;
   logic [IDX_W-1:0]       wordIdx;
   logic                   inRange;
   logic                   arrWriteEn;
   logic                   arrReadEn;
   logic                   rdGood;
   logic [DATA_BYTE*8-1:0] arrReadData;

   // Byte offset is dropped; any word-address bit above the index range marks the access out of range
   assign wordAddr = addr_i >> LOW_B;
   assign wordIdx  = wordAddr[IDX_W-1:0];
   assign inRange  = ((wordAddr >> IDX_W) == '0);

   // Decode the request phase from enable and the wait counter, and pick the next count
   always_comb begin
      phase   = PH_IDLE;
      cntNext = '0;
      if (enable_i) begin
         phase = (cnt == WAIT_CNT) ? PH_ACCEPT : PH_WAIT;
      end
      case (phase)
         PH_WAIT: cntNext = cnt + CNT_W'(1);
         default: cntNext = '0;
      endcase
   end

   assign hold_o = (phase == PH_WAIT);
   assign accept = (phase == PH_ACCEPT);

   // Wait counter; dropping enable mid-wait aborts the request and restarts the count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else begin
         cnt <= cntNext;
      end
   end

   // Out-of-range writes are dropped; nothing touches the array while reset is held
   assign arrWriteEn = accept && isWrite_i && inRange && !rst_i;
   assign arrReadEn  = accept && !isWrite_i && inRange && !rst_i;

   byte_mem_array #(
      .DATA_BYTE (DATA_BYTE),
      .DEPTH     (DEPTH)
   ) uArray (
      .clk_i     (clk_i),
      .writeEn   (arrWriteEn),
      .readEn    (arrReadEn),
      .byteMask  (writeMask_i),
      .wordIdx   (wordIdx),
      .writeData (writeData_i),
      .readData  (arrReadData)
   );

   // Remember whether the last accepted read hit the array; out-of-range reads and reset force zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdGood <= 1'b0;
      end else if (accept && !isWrite_i) begin
         rdGood <= inRange;
      end
   end

   assign readData_o = rdGood ? arrReadData : '0;

`ifdef SIMULATION
   // Parameter legality: power-of-two sizes and a wait count that fits the counter
   assert property (@(posedge clk_i)
      isPow2(DATA_BYTE) && isPow2(DEPTH) && (WAIT_CYCLES >= 0) && (WAIT_CYCLES <= MAX_WAIT))
      else $error("byte_mem_responder: illegal parameters");

   // The initiator must keep a stalled request stable unless it abandons it
   assert property (@(posedge clk_i) disable iff (rst_i)
      hold_o |=> (!enable_i || $stable({isWrite_i, writeMask_i, addr_i, writeData_i})))
      else $error("byte_mem_responder: request changed while held");
`endif

endmodule

// File: tb/tb_byte_mem_responder.sv
module tb_byte_mem_responder;

   localparam int NWORDS = 16;

   logic        clk = 1'b0;
   logic        rst;
   // Main DUT (WAIT_CYCLES = 2)
   logic        enable;
   logic        isWrite;
   logic [7:0]  writeMask;
   logic [31:0] addr;
   logic [63:0] writeData;
   logic [63:0] readData;
   logic        hold;
   // Zero-wait DUT
   logic        en0;
   logic        wr0;
   logic [7:0]  mask0;
   logic [31:0] addr0;
   logic [63:0] wdata0;
   logic [63:0] rdata0;
   logic        hold0;

   int checks = 0;
   int errors = 0;

   // Reference memories: word-level arrays indexed by byte address / 8
   logic [63:0] model  [NWORDS];
   logic [63:0] model0 [NWORDS];
   logic [63:0] lastRd;

   always #5 clk = ~clk;

   byte_mem_responder #(.DATA_BYTE(8), .ADDR_SIZE(32), .DEPTH(NWORDS), .WAIT_CYCLES(2)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .isWrite_i(isWrite),
      .writeMask_i(writeMask), .addr_i(addr), .writeData_i(writeData),
      .readData_o(readData), .hold_o(hold));

   byte_mem_responder #(.DATA_BYTE(8), .ADDR_SIZE(32), .DEPTH(NWORDS), .WAIT_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .enable_i(en0), .isWrite_i(wr0),
      .writeMask_i(mask0), .addr_i(addr0), .writeData_i(wdata0),
      .readData_o(rdata0), .hold_o(hold0));

   function automatic logic [63:0] refRead(input logic [31:0] a);
      if (a >= 32'(NWORDS * 8)) return 64'd0;
      return model[a / 8];
   endfunction

   task automatic modelWrite(input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
      if (a < 32'(NWORDS * 8)) begin
         for (int b = 0; b < 8; b++) begin
            if (m[b]) model[a / 8][b*8 +: 8] = d[b*8 +: 8];
         end
      end
   endtask

   // Issue one request on the main DUT, count hold cycles, return at negedge+1 after acceptance
   task automatic access(input logic wr, input logic [31:0] a, input logic [7:0] m,
                         input logic [63:0] d, output int holds);
      int guard;
      isWrite = wr; addr = a; writeMask = m; writeData = d; enable = 1'b1;
      holds = 0;
      guard = 0;
      #1;
      while (hold === 1'b1 && guard < 40) begin
         holds++; guard++;
         @(negedge clk); #1;
      end
      if (guard >= 40) begin
         checks++; errors++;
         $display("FAIL access_timeout addr=%h holds=%0d required hold release", a, holds);
      end
      @(negedge clk);
      enable = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b1; isWrite = 1'b0; addr = '0; writeMask = '0; writeData = '0;
      en0 = 1'b1; wr0 = 1'b0; addr0 = '0; mask0 = '0; wdata0 = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (readData !== 64'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", readData); end
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL reset_hold got=%b exp=1", hold); end
      checks++; if (rdata0 !== 64'd0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
      checks++; if (hold0 !== 1'b0) begin errors++; $display("FAIL reset_hold0 got=%b exp=0", hold0); end
      enable = 1'b0; en0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      lastRd = 64'd0;
      #1;
   endtask

   task automatic test_fill();
      int h;
      logic [63:0] d;
      for (int i = 0; i < NWORDS; i++) begin
         d = {$urandom, $urandom};
         access(1'b1, 32'(i * 8), 8'hFF, d, h);
         modelWrite(32'(i * 8), 8'hFF, d);
         checks++; if (h !== 2) begin errors++; $display("FAIL fill_hold word=%0d got=%0d exp=2", i, h); end
         checks++; if (readData !== lastRd) begin errors++; $display("FAIL fill_rdata_kept got=%h exp=%h", readData, lastRd); end
      end
   endtask

   task automatic test_write_read();
      int h;
      access(1'b1, 32'h08, 8'hFF, 64'h1122334455667788, h);
      modelWrite(32'h08, 8'hFF, 64'h1122334455667788);
      checks++; if (h !== 2) begin errors++; $display("FAIL wr_hold got=%0d exp=2", h); end
      access(1'b0, 32'h08, 8'h00, 64'd0, h);
      lastRd = 64'h1122334455667788;
      checks++; if (h !== 2) begin errors++; $display("FAIL rd_hold got=%0d exp=2", h); end
      checks++; if (readData !== lastRd) begin errors++; $display("FAIL wr_rd_data got=%h exp=%h", readData, lastRd); end
   endtask

   task automatic test_partial_mask();
      int h;
      access(1'b1, 32'h08, 8'h0F, 64'hAAAAAAAAAAAAAAAA, h);
      modelWrite(32'h08, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
      access(1'b0, 32'h08, 8'h00, 64'd0, h);
      lastRd = 64'h11223344AAAAAAAA;
      checks++; if (readData !== lastRd) begin errors++; $display("FAIL mask_rd got=%h exp=%h", readData, lastRd); end
      checks++; if (refRead(32'h08) !== lastRd) begin errors++; $display("FAIL mask_model got=%h exp=%h", refRead(32'h08), lastRd); end
      access(1'b0, 32'h0C, 8'h00, 64'd0, h);
      checks++; if (readData !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL lowbits_rd got=%h exp=11223344aaaaaaaa", readData); end
   endtask

   task automatic test_out_of_range();
      int h;
      access(1'b1, 32'h80, 8'hFF, 64'hDEAD, h);
      checks++; if (h !== 2) begin errors++; $display("FAIL oor_wr_hold got=%0d exp=2", h); end
      access(1'b0, 32'h80, 8'h00, 64'd0, h);
      lastRd = 64'd0;
      checks++; if (h !== 2) begin errors++; $display("FAIL oor_rd_hold got=%0d exp=2", h); end
      checks++; if (readData !== 64'd0) begin errors++; $display("FAIL oor_rd got=%h exp=0", readData); end
      access(1'b0, 32'h00, 8'h00, 64'd0, h);
      lastRd = refRead(32'h00);
      checks++; if (readData !== lastRd) begin errors++; $display("FAIL oor_word0 got=%h exp=%h", readData, lastRd); end
   endtask

   task automatic test_random();
      int h;
      logic        wr;
      logic [31:0] a;
      logic [7:0]  m;
      logic [63:0] d;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = $urandom | 32'h80;
         else a = 32'($urandom_range(0, NWORDS * 8 - 1));
         m = 8'($urandom);
         d = {$urandom, $urandom};
         access(wr, a, m, d, h);
         checks++; if (h !== 2) begin errors++; $display("FAIL rand_hold i=%0d got=%0d exp=2", i, h); end
         if (wr) begin
            modelWrite(a, m, d);
            checks++; if (readData !== lastRd) begin errors++; $display("FAIL rand_wr_keeps_rdata i=%0d got=%h exp=%h", i, readData, lastRd); end
         end else begin
            lastRd = refRead(a);
            checks++; if (readData !== lastRd) begin errors++; $display("FAIL rand_rd i=%0d addr=%h got=%h exp=%h", i, a, readData, lastRd); end
         end
      end
   endtask

   task automatic test_abort();
      int h;
      logic [63:0] old;
      old = model[3];
      @(negedge clk);
      isWrite = 1'b1; addr = 32'h18; writeMask = 8'hFF; writeData = ~old; enable = 1'b1;
      #1;
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL abort_hold got=%b exp=1", hold); end
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      access(1'b0, 32'h18, 8'h00, 64'd0, h);
      lastRd = old;
      checks++; if (h !== 2) begin errors++; $display("FAIL abort_next_hold got=%0d exp=2", h); end
      checks++; if (readData !== old) begin errors++; $display("FAIL abort_no_write got=%h exp=%h", readData, old); end
   endtask

   task automatic test_reset_mid_wait();
      int h;
      int guard;
      @(negedge clk);
      isWrite = 1'b0; addr = 32'h38; writeMask = '0; writeData = '0; enable = 1'b1;
      #1;
      @(negedge clk); #1;
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rmw_second_hold got=%b exp=1", hold); end
      rst = 1'b1;
      #1;
      checks++; if (readData !== 64'd0) begin errors++; $display("FAIL rmw_rdata_reset got=%h exp=0", readData); end
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rmw_hold_in_reset got=%b exp=1", hold); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      h = 0; guard = 0;
      while (hold === 1'b1 && guard < 40) begin
         h++; guard++;
         @(negedge clk); #1;
      end
      checks++; if (h !== 2) begin errors++; $display("FAIL rmw_restart_hold got=%0d exp=2", h); end
      checks++; if (readData !== 64'd0) begin errors++; $display("FAIL rmw_pre_accept got=%h exp=0", readData); end
      @(negedge clk);
      enable = 1'b0;
      #1;
      lastRd = model[7];
      checks++; if (readData !== lastRd) begin errors++; $display("FAIL rmw_data got=%h exp=%h", readData, lastRd); end
      rst = 1'b1;
      #1;
      checks++; if (readData !== 64'd0) begin errors++; $display("FAIL reset_after_read got=%h exp=0", readData); end
      @(negedge clk);
      rst = 1'b0;
      lastRd = 64'd0;
      #1;
   endtask

   task automatic test_zero_wait();
      logic [63:0] d;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         model0[i] = {$urandom, $urandom};
         en0 = 1'b1; wr0 = 1'b1; addr0 = 32'(i * 8); mask0 = 8'hFF; wdata0 = model0[i];
         #1;
         checks++; if (hold0 !== 1'b0) begin errors++; $display("FAIL zw_wr_hold i=%0d got=%b exp=0", i, hold0); end
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         wr0 = 1'b0; addr0 = 32'(i * 8);
         #1;
         checks++; if (hold0 !== 1'b0) begin errors++; $display("FAIL zw_rd_hold i=%0d got=%b exp=0", i, hold0); end
         if (i > 0) begin
            checks++; if (rdata0 !== model0[i-1]) begin errors++; $display("FAIL zw_stream i=%0d got=%h exp=%h", i - 1, rdata0, model0[i-1]); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if (rdata0 !== model0[3]) begin errors++; $display("FAIL zw_stream i=3 got=%h exp=%h", rdata0, model0[3]); end
      // Read-after-write one cycle apart
      d = {$urandom, $urandom};
      wr0 = 1'b1; addr0 = 32'h20; mask0 = 8'hFF; wdata0 = d;
      @(negedge clk);
      wr0 = 1'b0;
      @(negedge clk);
      en0 = 1'b0;
      #1;
      checks++; if (rdata0 !== d) begin errors++; $display("FAIL zw_raw got=%h exp=%h", rdata0, d); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_write_read();
      test_partial_mask();
      test_out_of_range();
      test_random();
      test_abort();
      test_reset_mid_wait();
      test_zero_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/byte_mem_responder.md
# byte_mem_responder

Memory-side responder for the byte-masked enable/isWrite/mask/addr/data/hold bus used by the byte-width converters. It owns a word-organised byte-enabled storage array and inserts a configurable number of wait states per access via `hold`. It terminates a converter's `mem*` port in simulation and FPGA builds, and serves as an on-chip scratch RAM.

## Interface
- `DATA_BYTE`, default 8: bytes per data word; power of two, ≥1.
- `ADDR_SIZE`, default 32: byte-address width.
- `DEPTH`, default 1024: number of words; power of two.
- `WAIT_CYCLES`, default 0: hold cycles inserted before each access is accepted; 0 to 15.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `enable_i`, input, 1: request valid.
- `isWrite_i`, input, 1: 1 = write, 0 = read.
- `writeMask_i`, input, DATA_BYTE: per-byte write enable.
- `addr_i`, input, ADDR_SIZE: byte address.
- `writeData_i`, input, DATA_BYTE*8: write data.
- `readData_o`, output, DATA_BYTE*8: read data, valid in the cycle after read acceptance.
- `hold_o`, output, 1: stall; the initiator keeps its request stable while this is 1.

## Operation
- Word index is `addr_i[LOW_BIT +: log2(DEPTH)]`, with `LOW_BIT = log2(DATA_BYTE)`. The low `LOW_BIT` bits are ignored.
- Address beyond the array (any bit above the index range set): reads return 0 and writes are dropped. Hold timing is identical to in-range accesses.
- Wait counter `cnt`, width 4, with states:
  - IDLE: `cnt == 0` and `enable_i` low.
  - WAIT: `enable_i` high and `cnt < WAIT_CYCLES`.
  - ACCEPT: `enable_i` high and `cnt == WAIT_CYCLES`.
- `hold_o = enable_i && (cnt != WAIT_CYCLES)`. This is combinational. It is constant 0 when `WAIT_CYCLES == 0`.
- Counter update:
  - WAIT: `cnt <= cnt + 1`.
  - ACCEPT: `cnt <= 0`.
  - `enable_i` low: `cnt <= 0`. A request dropped mid-wait is an abort; nothing is performed.
- Write accept: for each byte b with `writeMask_i[b]` set, the byte is stored at the clock edge ending the ACCEPT cycle. Unmasked bytes keep their value. An all-zero mask is a legal no-op access.
- Read accept: `readData_o` is registered with the addressed word at the ACCEPT edge. It holds that value until the next read acceptance. Write acceptances do not change `readData_o`.
- Back-to-back: after ACCEPT, a still-high `enable_i` starts a new access with `cnt = 0`. Throughput is one access per `WAIT_CYCLES + 1` cycles.
- `isWrite_i`, `addr_i`, `writeMask_i` and `writeData_i` are sampled only in the ACCEPT cycle. Changes during WAIT are tolerated but are protocol violations. The SIMULATION build asserts if they change while `hold_o` is 1.
- Storage is not reset; contents after power-up are undefined (X in simulation).

## Timing
- Reset values: `cnt = 0`, `readData_o = 0`. `hold_o` follows `enable_i` combinationally; during reset it equals `enable_i && WAIT_CYCLES != 0`.
- Read latency: data appears 1 cycle after the ACCEPT cycle. From first assertion of `enable_i` it is `WAIT_CYCLES + 1` cycles.
- Write becomes visible to a read accepted in the next cycle (read-after-write, 1 cycle apart, returns the new data).
- Reset asserted mid-wait: `cnt` clears at once, the pending access is lost, and `readData_o` becomes 0. After release the held request restarts with a full `WAIT_CYCLES`.
- Reset asserted in the cycle after a read ACCEPT: `readData_o` is 0 in that cycle, and the read data is lost.

## Structure
- Package `byte_mem_pkg`: `LOW_BIT` and `IDX_BITS` helper functions, and the `cnt` width constant.
- Sub-module `byte_mem_array`: synchronous single-port storage with per-byte write enable and registered read port. It maps to block RAM.
- `byte_mem_responder` contains the wait counter, hold generation, range check, read-register gating and SIMULATION assertions (power-of-two parameters, `WAIT_CYCLES ≤ 15`, request stability).

## Test plan
Bench parameters unless noted: `DATA_BYTE=8`, `DEPTH=16`, `WAIT_CYCLES=2`.
- Write then read: write `0x1122334455667788` to 0x08 with mask 0xFF, then read 0x08. `hold_o` is high for 2 cycles per access, and `readData_o = 0x1122334455667788` one cycle after the read ACCEPT.
- Partial mask: write `0xAAAA…` with mask 0x0F over the previous word, then read. Result is `0x11223344AAAAAAAA`. Reading 0x0C returns the same word (low bits ignored).
- Zero wait: with `WAIT_CYCLES=0`, run 4 back-to-back reads to 0x00, 0x08, 0x10, 0x18. `hold_o` stays 0 and the data stream out on consecutive cycles.
- Out of range: write `0xDEAD` to 0x80, then read 0x80. Result is 0, and word 0x00 is unchanged.
- Abort: raise `enable_i` for 1 cycle and drop it. No write occurs, `cnt` returns to 0, and the next request again holds 2 cycles.
- Reset mid-wait: assert `rst_i` during the second hold cycle of a read. `readData_o = 0` and the request restarts with 2 hold cycles after release.
